// File: rtl/hog_pkg.sv
// Shared types for the HOG back end: block record stored per FIFO entry
// and the packer FSM states.
package hog_pkg;
    localparam int BIN_W    = 12;
    localparam int NBINS    = 9;
    localparam int NCELLS   = 4;
    localparam int BLK_BINS = NCELLS * NBINS;
    localparam int SUM_W    = BIN_W + 6;

    // cells[c][k] is bin k of cell c; sum is the L1 norm of the whole block
    typedef struct packed {
        logic [NCELLS-1:0][NBINS-1:0][BIN_W-1:0] cells;
        logic [SUM_W-1:0]                        sum;
    } hog_blk_t;

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;
endpackage

// File: rtl/hog_blk_fifo.sv
// Small block FIFO; head entry is visible combinationally on rdata.
// Full-and-push is accepted only when a pop happens in the same cycle.
module hog_blk_fifo
    import hog_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  hog_blk_t                 wdata,
    output hog_blk_t                 rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    hog_blk_t       mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           wr_en;
    logic           rd_en;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);
    assign rdata = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/hog_block_packer.sv
// Captures 4-cell HOG blocks with their L1 sum, queues them and streams
// one bin per beat over valid/ready; blocks arriving into a full queue are dropped.
module hog_block_packer #(
    parameter int BIN_W = 12,
    parameter int NBINS = 9,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic [BIN_W*NBINS-1:0] cell0,
    input  logic [BIN_W*NBINS-1:0] cell1,
    input  logic [BIN_W*NBINS-1:0] cell2,
    input  logic [BIN_W*NBINS-1:0] cell3,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [BIN_W-1:0]       out_data,
    output logic [5:0]             out_idx,
    output logic                   out_last,
    output logic [BIN_W+5:0]       out_sum,
    output logic [15:0]            drop_cnt,
    output logic                   busy
);
    import hog_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;

    logic [NCELLS-1:0][BIN_W*NBINS-1:0] cell_bus;
    hog_blk_t   wr_blk;
    hog_blk_t   head;
    logic       full;
    logic       empty;
    logic [CW-1:0] count;
    logic       push;
    logic       pop;
    logic       hs;
    logic       at_last;

    state_t     state, state_n;
    logic [5:0] beat, beat_n;
    logic [1:0] cidx, cidx_n;
    logic [3:0] kidx, kidx_n;

    assign cell_bus = {cell3, cell2, cell1, cell0};

    // Bin 0 sits in the MSB slice of each cell bus
    always_comb begin
        logic [BIN_W+5:0] acc;
        wr_blk = '0;
        acc    = '0;
        for (int c = 0; c < NCELLS; c++) begin
            for (int k = 0; k < NBINS; k++) begin
                wr_blk.cells[c][k] = cell_bus[c][BIN_W*(NBINS-k)-1 -: BIN_W];
                acc = acc + (BIN_W+6)'(cell_bus[c][BIN_W*(NBINS-k)-1 -: BIN_W]);
            end
        end
        wr_blk.sum = acc;
    end

    assign out_valid = (state == STREAM);
    assign hs        = out_valid && out_ready;
    assign at_last   = (beat == 6'(BLK_BINS - 1));
    assign pop       = hs && at_last;
    assign push      = in_valid && (!full || pop);

    hog_blk_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata (wr_blk),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            beat  <= '0;
            cidx  <= '0;
            kidx  <= '0;
        end else begin
            state <= state_n;
            beat  <= beat_n;
            cidx  <= cidx_n;
            kidx  <= kidx_n;
        end
    end

    // Cell/bin indices are tracked alongside beat to avoid a divide-by-9
    always_comb begin
        state_n = state;
        beat_n  = beat;
        cidx_n  = cidx;
        kidx_n  = kidx;
        case (state)
            IDLE: begin
                if (push) begin
                    state_n = STREAM;
                    beat_n  = '0;
                    cidx_n  = '0;
                    kidx_n  = '0;
                end
            end
            STREAM: begin
                if (hs) begin
                    if (at_last) begin
                        beat_n = '0;
                        cidx_n = '0;
                        kidx_n = '0;
                        // Entry count after this pop decides whether the next block follows back-to-back
                        if (count <= CW'(1) && !push) state_n = IDLE;
                    end else begin
                        beat_n = beat + 1'b1;
                        if (kidx == 4'(NBINS - 1)) begin
                            kidx_n = '0;
                            cidx_n = cidx + 1'b1;
                        end else begin
                            kidx_n = kidx + 1'b1;
                        end
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            drop_cnt <= '0;
        else if (in_valid && full && !pop && drop_cnt != 16'hFFFF)
            drop_cnt <= drop_cnt + 1'b1;
    end

    assign out_data = out_valid ? head.cells[cidx][kidx] : '0;
    assign out_idx  = out_valid ? beat : '0;
    assign out_last = out_valid && at_last;
    assign out_sum  = out_valid ? head.sum : '0;
    assign busy     = !empty;
endmodule

// File: tb/tb_hog_block_packer.sv
// Directed bench for hog_block_packer: reset, single block, backpressure,
// overflow/max sum, push-while-popping-full and reset mid-stream.
module tb_hog_block_packer;
    localparam int BIN_W = 12;
    localparam int NBINS = 9;
    localparam int CB    = BIN_W * NBINS;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic [CB-1:0] cell0, cell1, cell2, cell3;
    logic          out_valid;
    logic          out_ready;
    logic [BIN_W-1:0] out_data;
    logic [5:0]    out_idx;
    logic          out_last;
    logic [BIN_W+5:0] out_sum;
    logic [15:0]   drop_cnt;
    logic          busy;

    int errors = 0;
    int checks = 0;

    hog_block_packer #(.BIN_W(BIN_W), .NBINS(NBINS), .DEPTH(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .cell0     (cell0),
        .cell1     (cell1),
        .cell2     (cell2),
        .cell3     (cell3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .out_sum   (out_sum),
        .drop_cnt  (drop_cnt),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_beat(input int idx, input int data, input int sum);
        chk("beat_valid", 32'(out_valid), 1);
        chk("beat_idx",   32'(out_idx), 32'(idx));
        chk("beat_data",  32'(out_data), 32'(data));
        chk("beat_sum",   32'(out_sum), 32'(sum));
        chk("beat_last",  32'(out_last), (idx == 35) ? 1 : 0);
    endtask

    task automatic chk_idle();
        chk("idle_valid", 32'(out_valid), 0);
        chk("idle_data",  32'(out_data), 0);
        chk("idle_idx",   32'(out_idx), 0);
        chk("idle_last",  32'(out_last), 0);
        chk("idle_sum",   32'(out_sum), 0);
        chk("idle_busy",  32'(busy), 0);
    endtask

    // mode 0: bin k of cell c = c*9+k+1; mode 1: all 4095; mode 2: all 1
    function automatic logic [CB-1:0] mk_cell(input int c, input int mode);
        logic [CB-1:0] v;
        logic [BIN_W-1:0] b;
        v = '0;
        for (int k = 0; k < NBINS; k++) begin
            case (mode)
                0:       b = BIN_W'(c*9 + k + 1);
                1:       b = 12'hFFF;
                default: b = 12'd1;
            endcase
            v[BIN_W*(NBINS-k)-1 -: BIN_W] = b;
        end
        return v;
    endfunction

    task automatic set_blk(input int mode);
        cell0 = mk_cell(0, mode);
        cell1 = mk_cell(1, mode);
        cell2 = mk_cell(2, mode);
        cell3 = mk_cell(3, mode);
    endtask

    initial begin
        int exp_beat;
        int seen;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        set_blk(0);

        // Reset with random inputs
        for (int i = 0; i < 3; i++) begin
            in_valid  = 1'($urandom);
            out_ready = 1'($urandom);
            cell0 = CB'({$urandom, $urandom, $urandom, $urandom});
            cell1 = CB'({$urandom, $urandom, $urandom, $urandom});
            tick();
            chk_idle();
            chk("rst_drop", 32'(drop_cnt), 0);
        end
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        tick();
        chk_idle();

        // Single block, sink always ready
        out_ready = 1'b1;
        set_blk(0); in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 36; i++) begin
            chk_beat(i, i + 1, 666);
            tick();
        end
        chk_idle();

        // Backpressure: ready alternates 0/1 starting at 0
        out_ready = 1'b0;
        set_blk(0); in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        exp_beat = 0; seen = 0;
        for (int j = 0; j < 72; j++) begin
            out_ready = 1'(j % 2);
            chk_beat(exp_beat, exp_beat + 1, 666);
            tick();
            if (j % 2 == 1) begin
                exp_beat++;
                seen++;
            end
        end
        chk("bp_seen", 32'(seen), 36);
        chk_idle();

        // Overflow: three pulses into a DEPTH=2 queue with sink stalled
        out_ready = 1'b0;
        set_blk(1);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        chk("ovf_drop", 32'(drop_cnt), 1);
        chk("ovf_busy", 32'(busy), 1);
        out_ready = 1'b1;
        for (int i = 0; i < 72; i++) begin
            chk_beat(i % 36, 4095, 147420);
            tick();
        end
        chk_idle();
        chk("ovf_drop_after", 32'(drop_cnt), 1);

        // Push on the cycle beat 35 of a full queue is accepted
        out_ready = 1'b0;
        set_blk(0); in_valid = 1'b1;
        tick();
        set_blk(1);
        tick();
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 36; i++) begin
            chk_beat(i, i + 1, 666);
            if (i == 35) begin
                set_blk(2);
                in_valid = 1'b1;
            end
            tick();
        end
        in_valid = 1'b0;
        chk("full_pp_drop", 32'(drop_cnt), 1);
        for (int i = 0; i < 36; i++) begin
            chk_beat(i, 4095, 147420);
            tick();
        end
        for (int i = 0; i < 36; i++) begin
            chk_beat(i, 1, 36);
            tick();
        end
        chk_idle();

        // Reset mid-stream at idx 10 with two blocks queued
        out_ready = 1'b0;
        set_blk(0); in_valid = 1'b1;
        tick();
        tick();
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        chk_beat(10, 11, 666);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk_idle();
        chk("mid_rst_drop", 32'(drop_cnt), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_idle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
